// File: rtl/nn_seq_pkg.sv
// Shared state encoding, default sizes and index-width helper for the two-layer MLP sequencer.
package nn_seq_pkg;

  localparam int unsigned N_IN_DEF   = 62;
  localparam int unsigned N_HID_DEF  = 30;
  localparam int unsigned N_OUT_DEF  = 10;
  localparam int unsigned N_TEST_DEF = 750;

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_CLR,
    S_H_MAC,
    S_H_ACT,
    S_O_CLR,
    S_O_MAC,
    S_O_ACT,
    S_CMP,
    S_FIN
  } seq_state_e;

  // Index width for a 0..n-1 counter; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_idx_counter.sv
// Modulo-MOD index counter: synchronous clear has priority, wraps to 0 only at MOD-1.
module nn_idx_counter
  import nn_seq_pkg::*;
#(
  parameter int unsigned MOD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [idx_w(MOD)-1:0]  idx,
  output logic                   last
);

  localparam int unsigned W    = idx_w(MOD);
  localparam logic [W-1:0] TERM = W'(MOD - 1);

  logic [W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = (idx_q == TERM) ? '0 : idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == TERM);

endmodule

// File: rtl/nn_mac_sequencer.sv
// Single-FSM sequencer for the two-layer MLP inference datapath; one full test set per start/done.
// Define NN_SEQ_STALL_EN to add a stall input that freezes the MAC states.
module nn_mac_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_HID  = N_HID_DEF,
  parameter int unsigned N_OUT  = N_OUT_DEF,
  parameter int unsigned N_TEST = N_TEST_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef NN_SEQ_STALL_EN
  input  logic                        stall,
`endif
  input  logic [idx_w(N_OUT)-1:0]     pred_class,
  input  logic [idx_w(N_OUT)-1:0]     label,
  output logic                        busy,
  output logic                        done,
  output logic                        layer_sel,
  output logic [idx_w(N_IN)-1:0]      in_idx,
  output logic [idx_w(N_HID)-1:0]     hid_idx,
  output logic [idx_w(N_OUT)-1:0]     out_idx,
  output logic [idx_w(N_TEST)-1:0]    test_idx,
  output logic                        acc_clr,
  output logic                        acc_en,
  output logic                        act_ld,
  output logic                        argmax_en,
  output logic                        correct_inc,
  output logic [idx_w(N_TEST+1)-1:0]  correct_cnt
);

  localparam int unsigned CW = idx_w(N_TEST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_TEST);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_w;
  logic          match;

  logic in_clr,   in_en,   in_last;
  logic hid_clr,  hid_en,  hid_last;
  logic out_clr,  out_en,  out_last;
  logic test_clr, test_en, test_last;

`ifdef NN_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign match = (pred_class == label);

  nn_idx_counter #(.MOD(N_IN)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (in_clr),
    .en   (in_en),
    .idx  (in_idx),
    .last (in_last)
  );

  // hid_idx doubles as the hidden neuron (H phase) and the O-phase source index.
  nn_idx_counter #(.MOD(N_HID)) u_hid_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (hid_clr),
    .en   (hid_en),
    .idx  (hid_idx),
    .last (hid_last)
  );

  nn_idx_counter #(.MOD(N_OUT)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (out_clr),
    .en   (out_en),
    .idx  (out_idx),
    .last (out_last)
  );

  nn_idx_counter #(.MOD(N_TEST)) u_test_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (test_clr),
    .en   (test_en),
    .idx  (test_idx),
    .last (test_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_clr      = 1'b0;
    in_en       = 1'b0;
    hid_clr     = 1'b0;
    hid_en      = 1'b0;
    out_clr     = 1'b0;
    out_en      = 1'b0;
    test_clr    = 1'b0;
    test_en     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    layer_sel   = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    act_ld      = 1'b0;
    argmax_en   = 1'b0;
    correct_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d  = S_H_CLR;
          cnt_d    = '0;
          in_clr   = 1'b1;
          hid_clr  = 1'b1;
          out_clr  = 1'b1;
          test_clr = 1'b1;
        end
      end
      S_H_CLR: begin
        acc_clr = 1'b1;
        in_clr  = 1'b1;
        state_d = S_H_MAC;
      end
      S_H_MAC: begin
        if (!stall_w) begin
          acc_en = 1'b1;
          in_en  = 1'b1;
          if (in_last) state_d = S_H_ACT;
        end
      end
      S_H_ACT: begin
        act_ld  = 1'b1;
        hid_en  = 1'b1;
        state_d = hid_last ? S_O_CLR : S_H_CLR;
      end
      S_O_CLR: begin
        layer_sel = 1'b1;
        acc_clr   = 1'b1;
        hid_clr   = 1'b1;
        state_d   = S_O_MAC;
      end
      S_O_MAC: begin
        layer_sel = 1'b1;
        if (!stall_w) begin
          acc_en = 1'b1;
          hid_en = 1'b1;
          if (hid_last) state_d = S_O_ACT;
        end
      end
      S_O_ACT: begin
        layer_sel = 1'b1;
        argmax_en = 1'b1;
        out_en    = 1'b1;
        state_d   = out_last ? S_CMP : S_O_CLR;
      end
      S_CMP: begin
        correct_inc = match;
        if (match && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
        // The final sample keeps test_idx at N_TEST-1 so it holds through FIN and IDLE.
        if (test_last) begin
          state_d = S_FIN;
        end else begin
          test_en = 1'b1;
          state_d = S_H_CLR;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign correct_cnt = cnt_q;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Scoreboard bench for nn_mac_sequencer: a loop-level reference model queues the expected busy-cycle trace.
module tb_nn_mac_sequencer;

  localparam int NI = 3;
  localparam int NH = 2;
  localparam int NO = 2;
  localparam int NT = 2;
  localparam int PS = NH * (NI + 2) + NO * (NH + 2) + 1;

  typedef logic [63:0] rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic [0:0] pred_class, label;
  logic       busy, done, layer_sel;
  logic [1:0] in_idx;
  logic [0:0] hid_idx, out_idx, test_idx;
  logic       acc_clr, acc_en, act_ld, argmax_en, correct_inc;
  logic [1:0] correct_cnt;
  logic [14:0] outvec;

  logic [0:0] pred_arr [NT];
  logic [0:0] lab_arr  [NT];
  bit         stall_off [256];

  rec_t q[$];
  int   pcnt = 0;
  int   base;
  int   total, bad;
  int   exp_done_off, exp_final;

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  nn_mac_sequencer #(
    .N_IN   (NI),
    .N_HID  (NH),
    .N_OUT  (NO),
    .N_TEST (NT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef NN_SEQ_STALL_EN
    .stall       (stall),
`endif
    .pred_class  (pred_class),
    .label       (label),
    .busy        (busy),
    .done        (done),
    .layer_sel   (layer_sel),
    .in_idx      (in_idx),
    .hid_idx     (hid_idx),
    .out_idx     (out_idx),
    .test_idx    (test_idx),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .act_ld      (act_ld),
    .argmax_en   (argmax_en),
    .correct_inc (correct_inc),
    .correct_cnt (correct_cnt)
  );

  always_comb begin
    pred_class = pred_arr[test_idx];
    label      = lab_arr[test_idx];
  end

  assign outvec = {busy, done, layer_sel, acc_clr, acc_en, act_ld, argmax_en, correct_inc,
                   in_idx, hid_idx, out_idx, test_idx, correct_cnt};

  // flags = {busy, done, acc_clr, acc_en, act_ld, argmax_en, correct_inc, layer_sel}
  function automatic rec_t mk(input int off, input logic [7:0] fl, input int a, input int b,
                              input int c, input int d, input int e);
    return {16'(off), fl, 8'(a), 8'(b), 8'(c), 8'(d), 8'(e)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Expected per-cycle trace of one run, built from nested loops over samples/neurons/inputs.
  task automatic model_run();
    int o   = 1;
    int cnt = 0;
    bit m;
    for (int t = 0; t < NT; t++) begin
      for (int h = 0; h < NH; h++) begin
        q.push_back(mk(o, 8'b1010_0000, 0, h, 0, t, cnt)); o++;
        for (int i = 0; i < NI; i++) begin
          while (stall_off[o]) begin q.push_back(mk(o, 8'b1000_0000, i, h, 0, t, cnt)); o++; end
          q.push_back(mk(o, 8'b1001_0000, i, h, 0, t, cnt)); o++;
        end
        q.push_back(mk(o, 8'b1000_1000, 0, h, 0, t, cnt)); o++;
      end
      for (int k = 0; k < NO; k++) begin
        q.push_back(mk(o, 8'b1010_0001, 0, 0, k, t, cnt)); o++;
        for (int j = 0; j < NH; j++) begin
          while (stall_off[o]) begin q.push_back(mk(o, 8'b1000_0001, 0, j, k, t, cnt)); o++; end
          q.push_back(mk(o, 8'b1001_0001, 0, j, k, t, cnt)); o++;
        end
        q.push_back(mk(o, 8'b1000_0101, 0, 0, k, t, cnt)); o++;
      end
      m = (pred_arr[t] == lab_arr[t]);
      q.push_back(mk(o, {6'b100000, m, 1'b0}, 0, 0, 0, t, cnt)); o++;
      if (m && cnt < NT) cnt++;
    end
    q.push_back(mk(o, 8'b1100_0000, 0, 0, 0, NT - 1, cnt));
    exp_done_off = o;
    exp_final    = cnt;
  endtask

  always @(negedge clk) begin
    rec_t act, exp;
    if (rst === 1'b1 && (busy | done | acc_clr | acc_en | act_ld | argmax_en | correct_inc) !== 1'b0) begin
      act = mk(pcnt - base, {busy, done, acc_clr, acc_en, act_ld, argmax_en, correct_inc, layer_sel},
               in_idx, hid_idx, out_idx, test_idx, correct_cnt);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=none", act);
      end else begin
        exp = q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL trace off=%0d got=%h want=%h", pcnt - base, act, exp);
        end
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns the offset at which done was seen.
  task automatic do_run(input bit inj_busy, input bit fin_start, output int done_off);
    int off = 0;
    done_off = -1;
    model_run();
    base  = pcnt;
    start = 1'b1;
    while (off < exp_done_off + 1) begin
      @(posedge clk); #1;
      off   = pcnt - base;
      start = 1'b0;
      stall = (off < 256) ? stall_off[off] : 1'b0;
      if (inj_busy && off >= 2 && off < exp_done_off && $urandom_range(0, 3) == 0) start = 1'b1;
      if (fin_start && off == exp_done_off) start = 1'b1;
      if (off == 1) chk("busy_rise", busy, 1);
      if (done && done_off < 0) done_off = off;
    end
    stall = 1'b0;
    chk("done_latency", done_off, exp_done_off);
    chk("busy_fall", busy, 0);
    chk("done_width", done, 0);
    chk("final_cnt", correct_cnt, exp_final);
    chk("hold_test_idx", test_idx, NT - 1);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic abort_run(input int at_off);
    int off = 0;
    model_run();
    base  = pcnt;
    start = 1'b1;
    while (off < at_off) begin
      @(posedge clk); #1;
      off   = pcnt - base;
      start = 1'b0;
    end
    chk("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_outputs_zero", outvec, 0);
    q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", {busy, done}, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_idle", outvec, 0);
  endtask

  task automatic rand_samples();
    for (int t = 0; t < NT; t++) begin
      pred_arr[t] = 1'($urandom);
      lab_arr[t]  = 1'($urandom);
    end
  endtask

  initial begin
    int doff;
    total = 0;
    bad   = 0;
    base  = 0;
    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    for (int k = 0; k < 256; k++) stall_off[k] = 1'b0;
    rand_samples();

    #2;
    chk("reset_outputs", outvec, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Only sample 0 matches.
    pred_arr[0] = 1'($urandom);
    lab_arr[0]  = pred_arr[0];
    pred_arr[1] = 1'($urandom);
    lab_arr[1]  = ~pred_arr[1];
    do_run(1'b0, 1'b0, doff);
    chk("done_at_formula", doff, 1 + NT * PS);
    chk("one_match_cnt", correct_cnt, 1);

    // All match, with starts injected while busy and during FIN.
    for (int t = 0; t < NT; t++) begin
      pred_arr[t] = 1'($urandom);
      lab_arr[t]  = pred_arr[t];
    end
    do_run(1'b1, 1'b1, doff);
    chk("all_match_cnt", correct_cnt, 2);

    // Start in the cycle right after FIN.
    rand_samples();
    do_run(1'b0, 1'b0, doff);

    abort_run(22);
    rand_samples();
    do_run(1'b1, 1'b0, doff);

`ifdef NN_SEQ_STALL_EN
    for (int k = 3; k <= 6; k++) stall_off[k] = 1'b1;
    rand_samples();
    do_run(1'b0, 1'b0, doff);
    chk("stall_done_delay", doff, 1 + NT * PS + 4);
    for (int k = 0; k < 256; k++) stall_off[k] = (k > 0 && k < 60) ? ($urandom_range(0, 3) == 0) : 1'b0;
    rand_samples();
    do_run(1'b1, 1'b0, doff);
    for (int k = 0; k < 256; k++) stall_off[k] = 1'b0;
`endif

    for (int r = 0; r < 4; r++) begin
      rand_samples();
      do_run(1'b1, r[0], doff);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
